// File: rtl/core_job_pkg.sv
// core_job_pkg: shared types and helpers for the Core job controller.
//   res_status_e : result status codes returned with each job
//   state_e      : controller FSM states
//   res_t        : result record held while waiting for res_ready
//   HDR_W/MS_W   : header (data1) and midstate bundle widths
//   bswap32      : 32-bit byte swap (header words are little-endian fields)
//   hdr_word     : extract 32-bit header word n (word0 = MSBs)
//   hdr_roll     : ntime roll, word1 += 1 in LE byte order, word3 (nonce) = 0
package core_job_pkg;

    localparam int HDR_W = 512;
    localparam int MS_W  = 768;

    typedef enum logic [1:0] {
        RS_FOUND     = 2'd0,
        RS_EXHAUSTED = 2'd1,
        RS_TIMEOUT   = 2'd2,
        RS_ABORTED   = 2'd3
    } res_status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_REPORT
    } state_e;

    typedef struct packed {
        logic [7:0]  id;
        res_status_e status;
        logic [1:0]  engine;
        logic [31:0] nonce;
        logic [31:0] tstamp;
    } res_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] hdr_word(input logic [HDR_W-1:0] h, input int idx);
        return h[HDR_W-1-32*idx -: 32];
    endfunction

    function automatic logic [HDR_W-1:0] hdr_roll(input logic [HDR_W-1:0] h);
        logic [HDR_W-1:0] r;
        r = h;
        r[HDR_W-33 -: 32] = bswap32(bswap32(h[HDR_W-33 -: 32]) + 32'd1);
        r[HDR_W-97 -: 32] = '0;
        return r;
    endfunction

endpackage

// File: rtl/job_wdog.sv
// job_wdog: saturating RUN-time watchdog.
//   clk, rst (async active-low)
//   clr  : zero the count (held while the job is settling)
//   en   : count this cycle
//   term : count has reached LIMIT-1; never asserts when LIMIT == 0
module job_wdog #(
    parameter logic [31:0] LIMIT = 32'd100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)   // saturate, never wrap
            cnt <= cnt + 32'd1;
    end

    assign term = (LIMIT != 32'd0) && (cnt == LIMIT - 32'd1);

endmodule

// File: rtl/core_job_ctrl.sv
// core_job_ctrl: feeds one mining Core with jobs and returns one result per job.
//   clk, rst (async active-low)
//   job_*  : job input handshake (valid/ready) with id, data1 header and midstates
//   core_* : drive (rst/en/data1/ms) and observe (blk_fnd/time/nonce/vrn_flg) the Core
//   res_*  : result handshake (valid/ready) with id, status, engine, nonce, time
// Build option: define NTIME_ROLL_EN to roll ntime (up to MAX_NTIME_ROLL times)
// instead of reporting EXHAUSTED on nonce-space exhaustion.
// SETTLE_CYC and RST_CYC must be >= 1.
module core_job_ctrl
    import core_job_pkg::*;
#(
    parameter int          RST_CYC        = 2,
    parameter int          SETTLE_CYC     = 4,
    parameter logic [31:0] TIMEOUT_CYC    = 32'd100_000_000,
    parameter int          MAX_NTIME_ROLL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [7:0]       job_id,
    input  logic [HDR_W-1:0] job_data1,
    input  logic [MS_W-1:0]  job_ms,
    input  logic             job_abort,
    output logic             core_rst,
    output logic             core_en,
    output logic [HDR_W-1:0] core_data1,
    output logic [MS_W-1:0]  core_ms,
    input  logic [2:0]       core_blk_fnd,
    input  logic [31:0]      core_time,
    input  logic [31:0]      core_nonce,
    input  logic             core_vrn_flg,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_id,
    output logic [1:0]       res_status,
    output logic [1:0]       res_engine,
    output logic [31:0]      res_nonce,
    output logic [31:0]      res_time
);

    state_e           state;
    logic [HDR_W-1:0] data1_q;
    logic [MS_W-1:0]  ms_q;
    logic [7:0]       id_q;
    logic [15:0]      ph_cnt;
    logic             vrn_q;
    res_t             res_q;
    logic             wdog_term;
    logic             vrn_rise;
    logic             fin;
    logic             roll;
    res_t             fin_res;

`ifdef NTIME_ROLL_EN
    logic [15:0]      roll_cnt;
`else
    logic             unused_roll;
    assign unused_roll = ^MAX_NTIME_ROLL;
`endif

    assign vrn_rise = core_vrn_flg && !vrn_q;

    // Watchdog is held clear through SETTLE, so it restarts on every RUN entry.
    job_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_SETTLE),
        .en   (state == ST_RUN),
        .term (wdog_term)
    );

    // Event arbitration: abort > found > exhaustion > watchdog.
    always_comb begin
        fin            = 1'b0;
        roll           = 1'b0;
        fin_res.id     = id_q;
        fin_res.status = RS_ABORTED;
        fin_res.engine = 2'd0;
        fin_res.nonce  = core_nonce;
        fin_res.tstamp = hdr_word(data1_q, 1);
        case (state)
            ST_LOAD, ST_SETTLE: begin
                // Core has not run yet: report the job's own starting nonce.
                if (job_abort) begin
                    fin           = 1'b1;
                    fin_res.nonce = hdr_word(data1_q, 3);
                end
            end
            ST_RUN: begin
                if (job_abort) begin
                    fin = 1'b1;
                end else if (core_blk_fnd != 3'd0) begin
                    fin            = 1'b1;
                    fin_res.status = RS_FOUND;
                    fin_res.engine = core_blk_fnd[1:0];
                    fin_res.tstamp = core_time;
                end else if (vrn_rise) begin
`ifdef NTIME_ROLL_EN
                    if (roll_cnt < 16'(MAX_NTIME_ROLL))
                        roll = 1'b1;
                    else
`endif
                    begin
                        fin            = 1'b1;
                        fin_res.status = RS_EXHAUSTED;
                    end
                end else if (wdog_term) begin
                    fin            = 1'b1;
                    fin_res.status = RS_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            job_ready <= 1'b0;
            core_rst  <= 1'b0;
            core_en   <= 1'b0;
            data1_q   <= '0;
            ms_q      <= '0;
            id_q      <= '0;
            ph_cnt    <= '0;
            vrn_q     <= 1'b0;
            res_valid <= 1'b0;
            res_q     <= '0;
`ifdef NTIME_ROLL_EN
            roll_cnt  <= '0;
`endif
        end else begin
            vrn_q <= core_vrn_flg;
            if (fin) begin
                res_q     <= fin_res;
                res_valid <= 1'b1;
                core_en   <= 1'b0;
                core_rst  <= 1'b0;
                state     <= ST_REPORT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        job_ready <= 1'b1;
                        if (job_ready && job_valid) begin
                            job_ready <= 1'b0;
                            data1_q   <= job_data1;
                            ms_q      <= job_ms;
                            id_q      <= job_id;
                            ph_cnt    <= '0;
                            core_rst  <= 1'b1;
                            state     <= ST_LOAD;
`ifdef NTIME_ROLL_EN
                            roll_cnt  <= '0;
`endif
                        end
                    end
                    ST_LOAD: begin
                        if (ph_cnt == 16'(RST_CYC - 1)) begin
                            core_rst <= 1'b0;
                            ph_cnt   <= '0;
                            state    <= ST_SETTLE;
                        end else begin
                            ph_cnt <= ph_cnt + 16'd1;
                        end
                    end
                    ST_SETTLE: begin
                        if (ph_cnt == 16'(SETTLE_CYC - 1)) begin
                            core_en <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            ph_cnt <= ph_cnt + 16'd1;
                        end
                    end
                    ST_RUN: begin
`ifdef NTIME_ROLL_EN
                        // Fresh ntime, nonce restarts at 0; reload the Core.
                        if (roll) begin
                            data1_q  <= hdr_roll(data1_q);
                            roll_cnt <= roll_cnt + 16'd1;
                            core_en  <= 1'b0;
                            core_rst <= 1'b1;
                            ph_cnt   <= '0;
                            state    <= ST_LOAD;
                        end
`endif
                    end
                    ST_REPORT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifndef NTIME_ROLL_EN
    logic unused_nroll;
    assign unused_nroll = roll;
`endif

    assign core_data1 = data1_q;
    assign core_ms    = ms_q;
    assign res_id     = res_q.id;
    assign res_status = res_q.status;
    assign res_engine = res_q.engine;
    assign res_nonce  = res_q.nonce;
    assign res_time   = res_q.tstamp;

endmodule

// File: tb/tb_core_job_ctrl.sv
// Directed bench for core_job_ctrl: found, exhausted (with/without ntime roll),
// timeout, abort priority, abort in SETTLE, result back-pressure, async reset.
module tb_core_job_ctrl;

    localparam int          RST_CYC    = 2;
    localparam int          SETTLE_CYC = 4;
    localparam logic [31:0] TMO        = 32'd16;
    localparam int          MAX_ROLL   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [7:0]   job_id = '0;
    logic [511:0] job_data1 = '0;
    logic [767:0] job_ms = '0;
    logic         job_abort = 1'b0;
    logic         core_rst;
    logic         core_en;
    logic [511:0] core_data1;
    logic [767:0] core_ms;
    logic [2:0]   core_blk_fnd = '0;
    logic [31:0]  core_time = '0;
    logic [31:0]  core_nonce = '0;
    logic         core_vrn_flg = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [7:0]   res_id;
    logic [1:0]   res_status;
    logic [1:0]   res_engine;
    logic [31:0]  res_nonce;
    logic [31:0]  res_time;

    always #5 clk = ~clk;

    core_job_ctrl #(
        .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC),
        .TIMEOUT_CYC(TMO), .MAX_NTIME_ROLL(MAX_ROLL)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .job_data1(job_data1), .job_ms(job_ms), .job_abort(job_abort),
        .core_rst(core_rst), .core_en(core_en), .core_data1(core_data1), .core_ms(core_ms),
        .core_blk_fnd(core_blk_fnd), .core_time(core_time), .core_nonce(core_nonce),
        .core_vrn_flg(core_vrn_flg),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_status(res_status), .res_engine(res_engine),
        .res_nonce(res_nonce), .res_time(res_time)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [511:0] d1;
    logic [767:0] ms;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input logic [7:0] id);
        job_id    = id;
        job_data1 = d1;
        job_ms    = ms;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("acc_core_rst", core_rst, 1);
        chk("acc_job_ready", job_ready, 0);
    endtask

    // Runs from the first LOAD cycle until core_en rises; counts reset and settle cycles.
    task automatic wait_en(input string tag);
        int rc, sc;
        rc = 0;
        sc = 0;
        for (int i = 0; i < 64 && !core_en; i++) begin
            if (core_rst) rc++; else sc++;
            tick();
        end
        chk({tag, "_en_up"}, core_en, 1);
        chk({tag, "_rst_cyc"}, rc, RST_CYC);
        chk({tag, "_settle_cyc"}, sc, SETTLE_CYC);
    endtask

    task automatic ack_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_ack_valid"}, res_valid, 0);
        chk({tag, "_ack_ready0"}, job_ready, 0);
        tick();
        chk({tag, "_ready_back"}, job_ready, 1);
    endtask

    initial begin
        d1 = '0;
        d1[511:480] = 32'h0200_0000;
        d1[479:448] = 32'hC7F5_D74D;
        d1[447:416] = 32'h1A2B_3C4D;
        d1[415:384] = 32'hA5A5_0003;
        ms = {256'h1111_2222_3333_4444, 256'h5555_6666, 256'h7777_8888_9999};

        // reset state
        tick(); tick();
        chk("rst_job_ready", job_ready, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_core_rst", core_rst, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_nonce", res_nonce, 0);
        chk("rst_data1_w1", core_data1[479:448], 0);
        rst = 1'b1;
        tick();
        chk("idle_ready", job_ready, 1);

        // abort in IDLE is ignored
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        chk("idle_abort_valid", res_valid, 0);
        chk("idle_abort_ready", job_ready, 1);

        // FOUND on engine 2, then 10 cycles of back-pressure
        send_job(8'h11);
        chk("t1_data1_w1", core_data1[479:448], 32'hC7F5_D74D);
        chk("t1_ms_eq", core_ms == ms, 1);
        wait_en("t1");
        core_blk_fnd = 3'b010;
        core_nonce   = 32'h1DAC_2B7C;
        core_time    = 32'h4DD7_F5C7;
        tick();
        core_blk_fnd = 3'b000;
        chk("t1_valid", res_valid, 1);
        chk("t1_core_en", core_en, 0);
        chk("t1_id", res_id, 8'h11);
        chk("t1_status", res_status, 0);
        chk("t1_engine", res_engine, 2);
        chk("t1_nonce", res_nonce, 32'h1DAC_2B7C);
        chk("t1_time", res_time, 32'h4DD7_F5C7);
        core_nonce = 32'hFFFF_0000;
        core_time  = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_hold_valid", res_valid, 1);
            chk("t1_hold_ready", job_ready, 0);
            chk("t1_hold_nonce", res_nonce, 32'h1DAC_2B7C);
        end
        ack_result("t1");

        // nonce-space exhaustion
        send_job(8'h22);
        wait_en("t2");
        core_nonce = 32'hCAFE_0001;
`ifdef NTIME_ROLL_EN
        core_vrn_flg = 1'b1;
        tick();
        core_vrn_flg = 1'b0;
        chk("t2_roll1_valid", res_valid, 0);
        chk("t2_roll1_rst", core_rst, 1);
        chk("t2_roll1_w1", core_data1[479:448], 32'hC8F5_D74D);
        chk("t2_roll1_w3", core_data1[415:384], 0);
        wait_en("t2r1");
        core_vrn_flg = 1'b1;
        tick();
        core_vrn_flg = 1'b0;
        chk("t2_roll2_valid", res_valid, 0);
        chk("t2_roll2_w1", core_data1[479:448], 32'hC9F5_D74D);
        wait_en("t2r2");
        core_vrn_flg = 1'b1;
        tick();
        core_vrn_flg = 1'b0;
        chk("t2_valid", res_valid, 1);
        chk("t2_status", res_status, 1);
        chk("t2_time", res_time, 32'hC9F5_D74D);
`else
        core_vrn_flg = 1'b1;
        tick();
        core_vrn_flg = 1'b0;
        chk("t2_valid", res_valid, 1);
        chk("t2_status", res_status, 1);
        chk("t2_time", res_time, 32'hC7F5_D74D);
`endif
        chk("t2_id", res_id, 8'h22);
        chk("t2_engine", res_engine, 0);
        chk("t2_nonce", res_nonce, 32'hCAFE_0001);
        ack_result("t2");

        // watchdog: 16 RUN cycles then TIMEOUT
        send_job(8'h33);
        wait_en("t3");
        core_nonce = 32'h0000_BEEF;
        begin
            int n;
            n = 0;
            while (core_en && n < 40) begin
                n++;
                tick();
            end
            chk("t3_run_cycles", n, 16);
        end
        chk("t3_valid", res_valid, 1);
        chk("t3_status", res_status, 2);
        chk("t3_nonce", res_nonce, 32'h0000_BEEF);
        chk("t3_time", res_time, 32'hC7F5_D74D);
        ack_result("t3");

        // abort beats blk_fnd in the same cycle
        send_job(8'h44);
        wait_en("t4");
        core_blk_fnd = 3'b001;
        job_abort    = 1'b1;
        core_nonce   = 32'h0BAD_0BAD;
        tick();
        core_blk_fnd = 3'b000;
        job_abort    = 1'b0;
        chk("t4_valid", res_valid, 1);
        chk("t4_status", res_status, 3);
        chk("t4_engine", res_engine, 0);
        chk("t4_nonce", res_nonce, 32'h0BAD_0BAD);
        ack_result("t4");

        // abort during SETTLE: no core_en pulse, nonce from data1[3]
        send_job(8'h55);
        tick(); tick();
        chk("t5_in_settle", core_rst, 0);
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        chk("t5_valid", res_valid, 1);
        chk("t5_status", res_status, 3);
        chk("t5_nonce", res_nonce, 32'hA5A5_0003);
        chk("t5_time", res_time, 32'hC7F5_D74D);
        begin
            logic en_seen;
            en_seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                en_seen |= core_en;
                tick();
            end
            chk("t5_no_en", en_seen, 0);
        end
        ack_result("t5");

        // raw blk_fnd 3'b100 is FOUND with engine bits 0
        send_job(8'h66);
        wait_en("t6");
        core_blk_fnd = 3'b100;
        core_time    = 32'h1234_5678;
        tick();
        core_blk_fnd = 3'b000;
        chk("t6_status", res_status, 0);
        chk("t6_engine", res_engine, 0);
        chk("t6_time", res_time, 32'h1234_5678);
        ack_result("t6");

        // async reset mid-RUN discards the job
        send_job(8'h77);
        wait_en("t7");
        tick();
        #3;
        rst = 1'b0;
        core_blk_fnd = 3'b001;
        #1;
        chk("t7_core_en", core_en, 0);
        chk("t7_core_rst", core_rst, 0);
        chk("t7_job_ready", job_ready, 0);
        chk("t7_data1", core_data1[479:448], 0);
        chk("t7_valid", res_valid, 0);
        tick(); tick();
        core_blk_fnd = 3'b000;
        rst = 1'b1;
        begin
            logic v_seen;
            v_seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                v_seen |= res_valid;
            end
            chk("t7_no_result", v_seen, 0);
        end
        chk("t7_ready_back", job_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_job_ctrl.md
Name: core_job_ctrl

Overview:
Work-side counterpart of the mining Core: accepts a job (16-word second-chunk header plus three midstates) over a valid/ready handshake and drives the Core's data1/ms_0..2/en/rst inputs. It then watches blk_fnd, inc_vrn_flg and cr_tme/crnt_nonce, and returns exactly one result record per job over a valid/ready handshake. It sits between the host/job FIFO and one Core instance.

Parameters:
RST_CYC, 2, cycles core_rst is held high per (re)load (min 1)
SETTLE_CYC, 4, cycles after core_rst falls before core_en asserts
TIMEOUT_CYC, 32'd100_000_000, RUN-state watchdog limit; 0 disables the watchdog
MAX_NTIME_ROLL, 8, maximum ntime rolls per job (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
job_valid  in  1  job offered
job_ready  out  1  job accepted when valid&ready
job_id  in  8  tag echoed in result
job_data1  in  512  header words 0..15, word0 = bits[511:480]
job_ms  in  768  ms_0 = [767:512], ms_1 = [511:256], ms_2 = [255:0]
job_abort  in  1  abandon current job
core_rst  out  1  active-high reset pulse to Core
core_en  out  1  Core enable
core_data1  out  512  data1 to Core
core_ms  out  768  ms_0..2 to Core
core_blk_fnd  in  3  Core blk_fnd (1/2/3 = engine, 0 = none)
core_time  in  32  Core cr_tme
core_nonce  in  32  Core crnt_nonce
core_vrn_flg  in  1  Core inc_vrn_flg (nonce space exhausted)
res_valid  out  1  result available
res_ready  in  1  result consumed when valid&ready
res_id  out  8  job_id of result
res_status  out  2  0 FOUND, 1 EXHAUSTED, 2 TIMEOUT, 3 ABORTED
res_engine  out  2  blk_fnd[1:0] when FOUND, else 0
res_nonce  out  32  core_nonce captured
res_time  out  32  core_time on FOUND; current data1[1] otherwise

Behaviour:
- Reset values: all outputs 0; job_ready=0; FSM=IDLE.
- FSM states: IDLE, LOAD, SETTLE, RUN, REPORT.
- IDLE: job_ready=1. On handshake, capture job_data1, job_ms and job_id; go to LOAD next cycle. job_ready=0 in every other state.
- LOAD: core_rst=1 for RST_CYC cycles; core_en=0; core_data1/core_ms driven from the captured registers, stable from LOAD through RUN.
- SETTLE: core_rst=0, core_en=0 for SETTLE_CYC cycles, then go to RUN.
- RUN: core_en=1; the watchdog counter increments every cycle. Priority, highest first:
  1. job_abort → ABORTED.
  2. core_blk_fnd!=0 → FOUND.
  3. Rising edge of core_vrn_flg (registered previous value) → EXHAUSTED, or a roll if the feature is enabled.
  4. Watchdog count == TIMEOUT_CYC-1 → TIMEOUT.
- Any RUN exit sets core_en=0 in the same cycle the result registers load. Result registers load the cycle the event is seen; res_valid=1 from the next cycle. Event-to-res_valid latency = 1 cycle.
- REPORT: res_valid and all res_* fields are held stable until res_ready. The handshake cycle clears res_valid and returns to IDLE; job_ready rises the following cycle.
- job_abort in LOAD/SETTLE: go straight to REPORT with ABORTED, res_nonce = data1[3]. job_abort in IDLE/REPORT is ignored.
- blk_fnd value 3'b100 or other non-{1,2,3} nonzero: treated as FOUND with res_engine=blk_fnd[1:0]; the value is reported raw, not fixed up.
- Watchdog clears on every entry to RUN. It saturates and never wraps.
- Asynchronous reset mid-job discards the job and any pending result; no result is emitted.

Optional Feature:
- Macro NTIME_ROLL_EN.
- Defined: a core_vrn_flg rising edge with roll_cnt < MAX_NTIME_ROLL does not report. Instead it rewrites data1[1] = bswap(bswap(data1[1])+1) (32-bit wrap), sets data1[3]=0, increments roll_cnt and returns to LOAD.
- Defined: at roll_cnt == MAX_NTIME_ROLL, report EXHAUSTED. roll_cnt clears on job accept.
- Undefined: every core_vrn_flg rising edge reports EXHAUSTED immediately; no roll counter is present.

Decomposition:
- Package core_job_pkg: res_status_e enum, fsm state enum, the HDR_W=512/MS_W=768 constants, and a bswap32 function.
- One sub-module, job_wdog: a saturating cycle counter with clear and a terminal flag.

Test Plan:
- Job id 0x11 accepted; core_blk_fnd=3'b010, core_nonce=0x1DAC2B7C, core_time=0x4DD7F5C7 in RUN → one result: status 0, engine 2, those values; core_en=0 the same cycle.
- core_vrn_flg pulse with macro off → EXHAUSTED, res_time = job data1[1]; with macro on and MAX_NTIME_ROLL=2 → two reloads with data1[1] 0xC7F5D74D→0xC8F5D74D→0xC9F5D74D, data1[3]=0, then EXHAUSTED.
- TIMEOUT_CYC=16, no Core events → TIMEOUT exactly 16 RUN cycles after entry.
- blk_fnd and job_abort asserted in the same cycle → ABORTED; job_abort during SETTLE → ABORTED with no core_en pulse.
- res_ready held low for 10 cycles → res_* stable, job_ready stays 0; rst low mid-RUN → all outputs 0, no result.
